adc_conditioner: RTL and testbench

Front-end conditioning and trigger stage on the antenna A2D path, clocked by `sink_clk`, sitting directly upstream of the time buffer. It converts raw offset-binary ADC samples to saturated two's complement and optionally removes DC offset. The conditioned stream drives the time buffer `sink_data`. A level trigger with a consecutive-sample qualifier and holdoff pulses the time buffer's `reset` so that a capture starts on an event.

---
 rtl/adc_cond_pkg.sv | 34 +++
 rtl/adc_conditioner_if.sv | 22 ++
 rtl/adc_trigger_fsm.sv | 89 ++++++++
 rtl/adc_conditioner.sv | 97 +++++++++
 tb/tb_adc_conditioner.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_cond_pkg.sv
// Shared types and saturation helpers for the ADC conditioning path.
// Pure declarations: no latency, no flow control.
package adc_cond_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_FIRE,
      ST_WAIT_LOW,
      ST_WAIT_HIGH,
      ST_HOLDOFF
   } trig_state_t;

   // Clamp a signed value to the symmetric range +/-(2^(width-1)-1).
   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int width);
      logic signed [31:0] lim;
      lim = (32'sd1 <<< (width - 1)) - 32'sd1;
      if (v > lim)
         return lim;
      else if (v < -lim)
         return -lim;
      return v;
   endfunction

   // Magnitude clamped to 2^(width-1)-1, so the most negative code folds onto +max.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int width);
      logic signed [31:0] lim;
      logic signed [31:0] a;
      lim = (32'sd1 <<< (width - 1)) - 32'sd1;
      a   = (v < 0) ? -v : v;
      return (a > lim) ? lim : a;
   endfunction

endpackage

// File: rtl/adc_conditioner_if.sv
// Sample-in / conditioned-out bundle between ADC, conditioner and time buffer.
// No latency; the time buffer only back-signals through buffer_ready.
interface adc_conditioner_if #(
   parameter int DATA_WIDTH = 14
);
   logic [DATA_WIDTH-1:0] adc_data;
   logic                  adc_ovr;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  trig_reset;
   logic                  buffer_ready;

   modport master (
      input  adc_data, adc_ovr, buffer_ready,
      output out_data, out_valid, trig_reset
   );

   modport slave (
      output adc_data, adc_ovr, buffer_ready,
      input  out_data, out_valid, trig_reset
   );
endinterface

// File: rtl/adc_trigger_fsm.sv
// Level trigger with consecutive-hit qualifier, time-buffer handshake and holdoff.
// Outputs registered, one cycle after the deciding sample; waits indefinitely on buffer_ready.
module adc_trigger_fsm
   import adc_cond_pkg::*;
#(
   parameter int DATA_WIDTH = 14,
   parameter int TRIG_COUNT = 3,
   parameter int HOLDOFF    = 4096
) (
   input  logic                  sink_clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-2:0] mag,
   input  logic                  out_valid,
   input  logic [DATA_WIDTH-2:0] threshold,
   input  logic                  arm,
   input  logic                  disarm,
   input  logic                  buffer_ready,
   output logic                  trig_reset,
   output logic                  armed,
   output logic                  busy
);
   localparam int HW  = $clog2(TRIG_COUNT + 1);
   localparam int HOW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   trig_state_t    state;
   logic [HW-1:0]  hit_cnt;
   logic [HOW-1:0] hold_cnt;
   logic           qualify;

   assign qualify = out_valid && (mag >= threshold);

   always_ff @(posedge sink_clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         hit_cnt    <= '0;
         hold_cnt   <= '0;
         trig_reset <= 1'b0;
         armed      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         trig_reset <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arm) begin
                  state   <= ST_ARMED;
                  hit_cnt <= '0;
                  armed   <= 1'b1;
               end
            end
            ST_ARMED: begin
               // disarm takes priority over a trigger completing on the same sample
               if (disarm) begin
                  state <= ST_IDLE;
                  armed <= 1'b0;
               end else if (qualify) begin
                  if (hit_cnt == HW'(TRIG_COUNT - 1)) begin
                     state      <= ST_FIRE;
                     armed      <= 1'b0;
                     busy       <= 1'b1;
                     trig_reset <= 1'b1;
                  end else begin
                     hit_cnt <= hit_cnt + HW'(1);
                  end
               end else begin
                  hit_cnt <= '0;
               end
            end
            ST_FIRE:      state <= ST_WAIT_LOW;
            ST_WAIT_LOW:  if (!buffer_ready) state <= ST_WAIT_HIGH;
            ST_WAIT_HIGH: begin
               if (buffer_ready) begin
                  state    <= ST_HOLDOFF;
                  hold_cnt <= HOW'(HOLDOFF - 1);
               end
            end
            ST_HOLDOFF: begin
               if (hold_cnt == '0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - HOW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/adc_conditioner.sv
// ADC front end: offset-binary to saturated two's complement, optional DC removal
// (ADC_DC_REMOVE_EN), trigger pulsing the time buffer reset. 2-cycle latency, no backpressure.
module adc_conditioner
   import adc_cond_pkg::*;
#(
   parameter int DATA_WIDTH = 14,
   parameter int DC_SHIFT   = 10,
   parameter int TRIG_COUNT = 3,
   parameter int HOLDOFF    = 4096
) (
   input  logic                  sink_clk,
   input  logic                  reset,
   adc_conditioner_if.master     bus,
   input  logic                  arm,
   input  logic                  disarm,
   input  logic [DATA_WIDTH-2:0] threshold,
   output logic                  armed,
   output logic                  busy,
   output logic [15:0]           overrange_cnt
);
   localparam int MSB = DATA_WIDTH - 1;
   localparam logic signed [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] NEG_MAX = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};

   logic signed [DATA_WIDTH-1:0] s1;
   logic signed [DATA_WIDTH-1:0] s1_next;
   logic signed [DATA_WIDTH-1:0] stage2;
   logic                         pipe_fill;
   logic [DATA_WIDTH-2:0]        mag;

   if (TRIG_COUNT < 1 || HOLDOFF < 1 || DC_SHIFT < 1) begin : g_bad_param
      $error("adc_conditioner: TRIG_COUNT, HOLDOFF and DC_SHIFT must be at least 1");
   end

   always_comb begin
      s1_next = {~bus.adc_data[MSB], bus.adc_data[MSB-1:0]};
      if (bus.adc_ovr)
         s1_next = bus.adc_data[MSB] ? POS_MAX : NEG_MAX;
   end

`ifdef ADC_DC_REMOVE_EN
   localparam int ACC_W = DATA_WIDTH + DC_SHIFT;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] dc;

   assign dc     = acc >>> DC_SHIFT;
   assign stage2 = DATA_WIDTH'(sat_signed(32'(s1) - 32'(dc), DATA_WIDTH));

   always_ff @(posedge sink_clk) begin
      if (reset)
         acc <= '0;
      else
         acc <= acc + ACC_W'(s1) - dc;
   end
`else
   assign stage2 = s1;
`endif

   always_ff @(posedge sink_clk) begin
      if (reset) begin
         s1            <= '0;
         pipe_fill     <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         overrange_cnt <= '0;
      end else begin
         s1            <= s1_next;
         pipe_fill     <= 1'b1;
         bus.out_valid <= pipe_fill;
         bus.out_data  <= stage2;
         if (bus.adc_ovr && overrange_cnt != 16'hFFFF)
            overrange_cnt <= overrange_cnt + 16'd1;
      end
   end

   assign mag = (DATA_WIDTH-1)'(sat_abs(32'($signed(bus.out_data)), DATA_WIDTH));

   adc_trigger_fsm #(
      .DATA_WIDTH (DATA_WIDTH),
      .TRIG_COUNT (TRIG_COUNT),
      .HOLDOFF    (HOLDOFF)
   ) u_trig (
      .sink_clk     (sink_clk),
      .reset        (reset),
      .mag          (mag),
      .out_valid    (bus.out_valid),
      .threshold    (threshold),
      .arm          (arm),
      .disarm       (disarm),
      .buffer_ready (bus.buffer_ready),
      .trig_reset   (bus.trig_reset),
      .armed        (armed),
      .busy         (busy)
   );

endmodule

// File: tb/tb_adc_conditioner.sv
// Directed plus randomized bench for adc_conditioner against an arithmetic reference model.
module tb_adc_conditioner;
   localparam int N    = 14;
   localparam int DCS  = 8;
   localparam int TC   = 3;
   localparam int HO   = 4096;
   localparam int MAXV = (1 << (N - 1)) - 1;

   logic          sink_clk = 1'b0;
   logic          reset    = 1'b1;
   logic          arm      = 1'b0;
   logic          disarm   = 1'b0;
   logic [N-2:0]  threshold = '0;
   logic          armed;
   logic          busy;
   logic [15:0]   overrange_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   int          mags[64];
   int          mlen;
   logic [N-1:0] raws[23];
   logic         ovrs[23];

   adc_conditioner_if #(.DATA_WIDTH(N)) bus ();

   adc_conditioner #(
      .DATA_WIDTH (N),
      .DC_SHIFT   (DCS),
      .TRIG_COUNT (TC),
      .HOLDOFF    (HO)
   ) dut (
      .sink_clk      (sink_clk),
      .reset         (reset),
      .bus           (bus),
      .arm           (arm),
      .disarm        (disarm),
      .threshold     (threshold),
      .armed         (armed),
      .busy          (busy),
      .overrange_cnt (overrange_cnt)
   );

   always #5 sink_clk = ~sink_clk;

   task automatic tick();
      @(posedge sink_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // offset-binary code carrying the signed value v
   function automatic logic [N-1:0] raw_of(input int v);
      int t;
      t = v + (1 << (N - 1));
      return t[N-1:0];
   endfunction

   // signed sample value the ADC code stands for, clipped on overrange
   function automatic int exp_val(input logic [N-1:0] raw, input logic ovr);
      if (ovr)
         return raw[N-1] ? MAXV : -MAXV;
      return int'(raw) - (1 << (N - 1));
   endfunction

   function automatic int out_sval();
      return int'($signed(bus.out_data));
   endfunction

   task automatic reset_vals(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_out_data"}, bus.out_data, 0);
      chk({tag, "_trig_reset"}, bus.trig_reset, 0);
      chk({tag, "_armed"}, armed, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ovr_cnt"}, overrange_cnt, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      arm = 1'b0;
      disarm = 1'b0;
      bus.adc_ovr = 1'b0;
      bus.adc_data = raw_of(0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
   endtask

   // arm, play mags[] with alternating sign, compare against the first run of TC hits
   task automatic trig_trial(input string tag, input int thr, input bit dis);
      int k, run, pulses, ptick, smp;
      k = -1;
      run = 0;
      for (int i = 0; i < mlen; i++) begin
         run = (mags[i] >= thr) ? run + 1 : 0;
         if (run == TC && k < 0) k = i;
      end
      threshold = (N-1)'(thr);
      bus.adc_data = raw_of(0);
      tick();
      tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk({tag, "_armed"}, armed, 1);
      pulses = 0;
      ptick = -1;
      for (int t = 1; t <= mlen + 4; t++) begin
         if (t - 1 < mlen)
            smp = ((t - 1) % 2 == 1) ? -mags[t-1] : mags[t-1];
         else
            smp = 0;
         bus.adc_data = raw_of(smp);
         disarm = dis && (k >= 0) && (t == k + 3);
         tick();
         if (bus.trig_reset) begin
            pulses++;
            if (ptick < 0) ptick = t;
         end
         if (dis && k >= 0 && t == k + 3)
            chk({tag, "_disarm_armed"}, armed, 0);
      end
      disarm = 1'b0;
      bus.adc_data = raw_of(0);
      if (k >= 0 && !dis) begin
         chk({tag, "_pulses"}, pulses, 1);
         chk({tag, "_pulse_cycle"}, ptick, k + 3);
      end else begin
         chk({tag, "_pulses"}, pulses, 0);
      end
      chk({tag, "_armed_end"}, armed, (k < 0) ? 1 : 0);
      chk({tag, "_busy_end"}, busy, (k >= 0 && !dis) ? 1 : 0);
   endtask

   task automatic fire_lat(input string tag, input int thr, input logic [N-1:0] raw);
      int c;
      threshold = (N-1)'(thr);
      bus.adc_data = raw;
      bus.adc_ovr = 1'b0;
      tick();
      tick();
      tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      c = 0;
      while (!bus.trig_reset && c < 20) begin
         tick();
         c++;
      end
      chk({tag, "_fire_latency"}, c, TC);
   endtask

   initial begin
      int novr, c, thr, m, exp_cnt;
      bus.adc_data = raw_of(0);
      bus.adc_ovr = 1'b0;
      bus.buffer_ready = 1'b1;

      // reset state and out_valid rise
      tick();
      tick();
      reset_vals("reset");
      reset = 1'b0;
      tick();
      chk("valid_cycle1", bus.out_valid, 0);
      tick();
      chk("valid_cycle2", bus.out_valid, 1);

      // format conversion: directed codes then random codes with random overrange
      raws[0] = 14'h2000; raws[1] = 14'h3FFF; raws[2] = 14'h0000;
      ovrs[0] = 1'b0;     ovrs[1] = 1'b0;     ovrs[2] = 1'b0;
      for (int i = 3; i < 23; i++) begin
         raws[i] = N'($urandom_range(0, (1 << N) - 1));
         ovrs[i] = ($urandom_range(0, 3) == 0);
      end
      novr = 0;
      for (int i = 0; i < 23; i++) begin
         bus.adc_data = raws[i];
         bus.adc_ovr = ovrs[i];
         novr += int'(ovrs[i]);
         tick();
`ifndef ADC_DC_REMOVE_EN
         if (i >= 1) chk($sformatf("conv%0d", i - 1), out_sval(), exp_val(raws[i-1], ovrs[i-1]));
`endif
      end
      bus.adc_ovr = 1'b0;
      tick();
`ifndef ADC_DC_REMOVE_EN
      chk("conv22", out_sval(), exp_val(raws[22], ovrs[22]));
`endif
      chk("conv_ovr_cnt", overrange_cnt, novr);

      // overrange clipping and counter saturation
      do_reset();
      bus.adc_data = 14'h0005;
      bus.adc_ovr = 1'b1;
      tick();
      tick();
      tick();
      bus.adc_ovr = 1'b0;
`ifndef ADC_DC_REMOVE_EN
      chk("ovr_clip_neg", out_sval(), -MAXV);
`endif
      chk("ovr_cnt3", overrange_cnt, 3);
      bus.adc_ovr = 1'b1;
      repeat (66000) tick();
      bus.adc_ovr = 1'b0;
      tick();
      exp_cnt = (3 + 66000 > 65535) ? 65535 : 3 + 66000;
      chk("ovr_cnt_sat", overrange_cnt, exp_cnt);

      // trigger qualification with one sub-threshold sample in the run
      do_reset();
      mlen = 6;
      mags[0] = 1200; mags[1] = 1200; mags[2] = 900;
      mags[3] = 1200; mags[4] = 1200; mags[5] = 1200;
      trig_trial("trig_qual", 1000, 1'b0);

      // full capture loop with a modelled time buffer; arm while busy is ignored
      bus.buffer_ready = 1'b0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("busy_arm_ignored", armed, 0);
      repeat (2049) tick();
      chk("busy_ready_low", busy, 1);
      bus.buffer_ready = 1'b1;
      tick();
      c = 0;
      while (busy && c < HO + 10) begin
         tick();
         c++;
      end
      chk("holdoff_cycles", c, HO);
      chk("idle_after_holdoff_armed", armed, 0);

      // disarm on the same sample that completes the run
      mlen = 3;
      mags[0] = 1200; mags[1] = 1200; mags[2] = 1200;
      trig_trial("disarm", 1000, 1'b1);

      // random magnitudes kept clear of the threshold by a margin
      thr = $urandom_range(500, 1500);
      mlen = 30;
      for (int i = 0; i < mlen; i++) begin
         m = $urandom_range(0, 2000);
         if (m > thr - 40 && m < thr + 40) m = thr + 40;
         mags[i] = m;
      end
      trig_trial("rand", thr, 1'b0);
      do_reset();

      // threshold 0 fires after TC samples, then reset while in WAIT_HIGH
      fire_lat("thr_zero", 0, raw_of(0));
      bus.buffer_ready = 1'b0;
      bus.adc_ovr = 1'b1;
      tick();
      tick();
      bus.adc_ovr = 1'b0;
      chk("wait_high_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset_vals("midreset");
      bus.buffer_ready = 1'b1;
      reset = 1'b0;
      tick();
      tick();

`ifndef ADC_DC_REMOVE_EN
      // most negative code folds to +max magnitude and meets the max threshold
      fire_lat("thr_max", MAXV, raw_of(-(1 << (N - 1))));
      do_reset();
`endif

`ifdef ADC_DC_REMOVE_EN
      // constant +1024 decays toward zero
      reset = 1'b1;
      bus.adc_data = raw_of(1024);
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("dc_first", out_sval(), 1024);
      repeat (16 << DCS) tick();
      chk("dc_settled", (out_sval() <= 2 && out_sval() >= -2) ? 1 : 0, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
